// File: rtl/counter_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
// Holds the FSM state encoding and the requester-index width derivation.
package counter_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int m);
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/counter_rr_scheduler_if.sv
// Request/grant bundle between step generators (master) and the scheduler (slave).
interface counter_rr_scheduler_if #(
   parameter int N = 4,
   parameter int M = 4
);
   import counter_rr_scheduler_pkg::*;

   localparam int ID_W = id_width(M);

   logic [M-1:0]   req;
   logic [M*N-1:0] req_len;
   logic [M-1:0]   gnt;
   logic [ID_W-1:0] gnt_id;
   logic [N-1:0]   count;
   logic           busy;
   logic           done;
   logic           abort;

   modport master (
      output req, req_len,
      input  gnt, gnt_id, count, busy, done, abort
   );

   modport slave (
      input  req, req_len,
      output gnt, gnt_id, count, busy, done, abort
   );

endinterface

// File: rtl/counter_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo M.
module rr_pick
   import counter_rr_scheduler_pkg::*;
#(
   parameter int M    = 4,
   parameter int ID_W = id_width(M)
) (
   input  logic [M-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] winner,
   output logic [M-1:0]    winner_oh
);

   always_comb begin
      int idx;
      logic [ID_W-1:0] idx_v;
      any       = 1'b0;
      winner    = '0;
      winner_oh = '0;
      idx       = 0;
      idx_v     = '0;
      for (int i = 0; i < M; i++) begin
         idx = int'(ptr) + i;
         if (idx >= M) idx = idx - M;
         idx_v = ID_W'(idx);
         if (!any && req[idx_v]) begin
            any              = 1'b1;
            winner           = idx_v;
            winner_oh[idx_v] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one up-counter between M requesters; each winner
// gets a (len+1)-cycle window and a registered done/abort pulse when it ends.
module counter_rr_scheduler
   import counter_rr_scheduler_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   counter_rr_scheduler_if.slave  bus
);

   localparam int ID_W = id_width(M);

   state_e          state_q, state_d;
   logic [N-1:0]    count_q, count_d;
   logic [N-1:0]    len_q, len_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic [M-1:0]    gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            abort_q, abort_d;

   logic            pick_any;
   logic [ID_W-1:0] pick_id;
   logic [M-1:0]    pick_oh;
   logic [N-1:0]    len_sel;
   logic            run_drop, run_term, cnt_clr, cnt_en;

   rr_pick #(.M(M), .ID_W(ID_W)) u_pick (
      .req       (bus.req),
      .ptr       (ptr_q),
      .any       (pick_any),
      .winner    (pick_id),
      .winner_oh (pick_oh)
   );

   always_comb begin
      len_sel = '0;
      for (int i = 0; i < M; i++) begin
         if (pick_id == ID_W'(i)) len_sel = bus.req_len[i*N +: N];
      end
   end

   // A dropped request ends the window even on the terminal cycle.
   assign run_drop = (state_q == ST_RUN) && !bus.req[gnt_id_q];
   assign run_term = (state_q == ST_RUN) && (count_q == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_any) state_d = ST_RUN;
         ST_RUN:  if (run_drop || run_term) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      len_d    = len_q;
      ptr_d    = ptr_q;
      gnt_id_d = gnt_id_q;
      gnt_d    = gnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               cnt_clr  = 1'b1;
               len_d    = len_sel;
               gnt_id_d = pick_id;
               gnt_d    = pick_oh;
               busy_d   = 1'b1;
            end
         end
         ST_RUN: begin
            if (run_drop || run_term) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               abort_d = run_drop;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            ptr_d = (gnt_id_q == ID_W'(M - 1)) ? '0 : gnt_id_q + 1'b1;
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
      count_d = cnt_clr ? '0 : (cnt_en ? count_q + 1'b1 : count_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         len_q    <= '0;
         ptr_q    <= '0;
         gnt_id_q <= '0;
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         len_q    <= len_d;
         ptr_q    <= ptr_d;
         gnt_id_q <= gnt_id_d;
         gnt_q    <= gnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt_id = gnt_id_q;
   assign bus.count  = count_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.abort  = abort_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Scoreboard bench for counter_rr_scheduler: stimulus queues expected windows,
// a negedge monitor checks every busy cycle and each done pulse against them.
module tb_counter_rr_scheduler;

   localparam int N = 4;
   localparam int M = 4;

   typedef struct {
      int id;
      int cycles;
      int abort;
      int gap;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t exp_q[$];
   int   n_vec;
   int   n_err;

   counter_rr_scheduler_if #(.N(N), .M(M)) bus ();

   counter_rr_scheduler #(.N(N), .M(M)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req_v);
      n_vec++;
      if (act != req_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req_v, $time);
      end
   endtask

   task automatic push(input int id, input int cycles, input int ab, input int gap);
      exp_t e;
      e.id = id; e.cycles = cycles; e.abort = ab; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic wait_count(input int c, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.busy && int'(bus.count) == c) return;
      end
      chk("count_timeout", 0, 1);
   endtask

   task automatic set_len(input int i, input int v);
      bus.req_len[i*N +: N] = N'(v);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: window shape per busy cycle, window summary on done.
   initial begin
      bit in_win;
      int win_len, cur_id, cur_gap, cyc, last_busy;
      exp_t e;
      in_win = 0; win_len = 0; cur_id = 0; cur_gap = 0; cyc = 0; last_busy = -100;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_win = 0;
            last_busy = -100;
         end else begin
            if (bus.busy) begin
               if (!in_win) begin
                  in_win  = 1;
                  win_len = 0;
                  cur_id  = int'(bus.gnt_id);
                  cur_gap = cyc - last_busy;
               end
               chk("gnt_onehot", int'(bus.gnt), 1 << cur_id);
               chk("count_seq", int'(bus.count), win_len);
               win_len++;
               last_busy = cyc;
            end
            if (bus.done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("win_id", cur_id, e.id);
                  chk("win_cycles", win_len, e.cycles);
                  chk("win_abort", int'(bus.abort), e.abort);
                  chk("done_busy", int'(bus.busy), 0);
                  chk("done_gnt", int'(bus.gnt), 0);
                  chk("done_count_hold", int'(bus.count), win_len - 1);
                  if (e.gap >= 0) chk("grant_gap", cur_gap, e.gap);
               end
               in_win = 0;
            end
         end
         cyc++;
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req = '0;
      bus.req_len = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_gnt_id", int'(bus.gnt_id), 0);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_gnt", int'(bus.gnt), 0);
      chk("idle_busy", int'(bus.busy), 0);

      // Single request: requester 1, len 3 -> counts 0..3, done no abort
      set_len(1, 3);
      bus.req = 4'b0010;
      push(1, 4, 0, -1);
      @(negedge clk);
      chk("lat_busy", int'(bus.busy), 1);
      chk("lat_count", int'(bus.count), 0);
      wait_done(20);
      bus.req = '0;

      // Round-robin from a fresh pointer, all len 0
      pulse_reset();
      bus.req_len = '0;
      bus.req = 4'b1111;
      push(0, 1, 0, -1);
      push(1, 1, 0, 3);
      push(2, 1, 0, 3);
      push(3, 1, 0, 3);
      push(0, 1, 0, 3);
      for (int k = 0; k < 5; k++) wait_done(20);
      bus.req = '0;

      // Full-width window: len 15 gives 16 cycles, no wrap
      set_len(0, 15);
      bus.req = 4'b0001;
      push(0, 16, 0, -1);
      wait_done(40);
      bus.req = '0;

      // Abort: requester 2 len 10 dropped at count 4; pointer then favours 3 over 0
      set_len(2, 10);
      set_len(3, 1);
      bus.req = 4'b0100;
      push(2, 5, 1, -1);
      push(3, 2, 0, 3);
      wait_count(4, 20);
      bus.req = 4'b1001;
      wait_done(20);
      wait_done(20);
      bus.req = '0;

      // Length stability: change len mid-window, new value used on next grant
      set_len(1, 6);
      bus.req = 4'b0010;
      push(1, 7, 0, -1);
      push(1, 3, 0, 3);
      wait_count(2, 20);
      set_len(1, 2);
      wait_done(20);
      wait_done(20);
      bus.req = '0;

      // Reset mid-RUN: outputs clear immediately, no done pulse
      set_len(3, 8);
      bus.req = 4'b1000;
      wait_count(3, 20);
      #2 rst_n = 1'b0;
      bus.req = '0;
      #1;
      chk("midrst_gnt", int'(bus.gnt), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_count", int'(bus.count), 0);
      chk("midrst_done", int'(bus.done), 0);
      chk("midrst_abort", int'(bus.abort), 0);
      chk("midrst_gnt_id", int'(bus.gnt_id), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", int'(bus.busy), 0);
      chk("post_rst_gnt", int'(bus.gnt), 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
